// File: rtl/pd_seq_pkg.sv
// Shared state encoding and default sizing for the pattern-detector stream sequencer.
// No logic; constants only.
package pd_seq_pkg;

  localparam int WORD_W_DEF     = 8;
  localparam int GAP_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 16;
  localparam int LED_W_DEF      = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    TRIG   = 3'd2,
    HOLD   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/pd_bit_serializer.sv
// Parallel-load MSB-first shift register with a bit counter; last flags the final bit.
// Load/shift take effect on the next clock; no backpressure, the owner sequences it.
module pd_bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic              bit_out,
  output logic              last
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shreg_d   = load_data;
      bit_cnt_d = CW'(WORD_W - 1);
    end else if (shift) begin
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_out = shreg_q[WORD_W-1];
  assign last    = (bit_cnt_q == '0);

endmodule

// File: rtl/pd_stream_sequencer.sv
// Serializes accepted words MSB-first onto pd_data/pd_trig and samples the detector after each bit.
// Accept-to-done is WORD_W*(GAP_CYCLES+3)+1 cycles; word_ready is high only in IDLE.
module pd_stream_sequencer
  import pd_seq_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LED_W      = LED_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              abort,
  input  logic              clear_count,
  output logic              pd_data,
  output logic              pd_trig,
  input  logic [LED_W-1:0]  pd_led,
  input  logic              pd_on_led,
  output logic [LED_W-1:0]  led_snap,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_e       state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [LED_W-1:0] led_snap_q, led_snap_d;

  logic ser_load, ser_shift, ser_bit, ser_last;

  pd_bit_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (word_data),
    .bit_out   (ser_bit),
    .last      (ser_last)
  );

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    match_count_d = match_count_q;
    led_snap_d    = led_snap_q;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    word_ready    = 1'b0;
    pd_trig       = 1'b0;
    pd_data       = 1'b0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);

    case (state_q)
      IDLE: begin
        word_ready = !reset;
        if (word_valid && !reset) begin
          ser_load = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pd_data = ser_bit;
        state_d = TRIG;
      end
      TRIG: begin
        pd_data   = ser_bit;
        pd_trig   = 1'b1;
        gap_cnt_d = GW'(GAP_CYCLES - 1);
        state_d   = HOLD;
      end
      HOLD: begin
        pd_data = ser_bit;
        if (gap_cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        pd_data    = ser_bit;
        led_snap_d = pd_led;
        if (pd_on_led && (match_count_q != '1)) begin
          match_count_d = match_count_q + 1'b1;
        end
        if (ser_last) begin
          state_d = DONE;
        end else begin
          ser_shift = 1'b1;
          state_d   = SETUP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An abort discards the partial word without touching the sampled results.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      pd_trig       = 1'b0;
      ser_shift     = 1'b0;
      gap_cnt_d     = gap_cnt_q;
      match_count_d = match_count_q;
      led_snap_d    = led_snap_q;
    end

    if (clear_count) begin
      match_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      match_count_q <= '0;
      led_snap_q    <= '0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      match_count_q <= match_count_d;
      led_snap_q    <= led_snap_d;
    end
  end

  assign match_count = match_count_q;
  assign led_snap    = led_snap_q;

endmodule

// File: tb/tb_pd_stream_sequencer.sv
// Scoreboard bench: stimulus queues expected trig bits and done results; a negedge monitor checks them.
module tb_pd_stream_sequencer;

  localparam int WW     = 8;
  localparam int GAP    = 2;
  localparam int LW     = 5;
  localparam int PERIOD = GAP + 3;
  localparam int LAT    = WW * PERIOD + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, word_valid, abort, clear_count, pd_on_led;
  logic [WW-1:0] word_data;
  logic [LW-1:0] pd_led;
  logic          word_ready, pd_data, pd_trig, busy, done;
  logic [LW-1:0] led_snap;
  logic [15:0]   match_count;

  logic          s_word_valid, s_abort, s_clear, s_on_led;
  logic [WW-1:0] s_word_data;
  logic [LW-1:0] s_pd_led;
  logic          s_word_ready, s_pd_data, s_pd_trig, s_busy, s_done;
  logic [LW-1:0] s_led_snap;
  logic [2:0]    s_match;

  pd_stream_sequencer #(.WORD_W(WW), .GAP_CYCLES(GAP), .CNT_W(16), .LED_W(LW)) dut (
    .clk(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .abort(abort), .clear_count(clear_count),
    .pd_data(pd_data), .pd_trig(pd_trig), .pd_led(pd_led), .pd_on_led(pd_on_led),
    .led_snap(led_snap), .match_count(match_count), .busy(busy), .done(done)
  );

  pd_stream_sequencer #(.WORD_W(WW), .GAP_CYCLES(GAP), .CNT_W(3), .LED_W(LW)) dut_sat (
    .clk(clk), .reset(reset), .word_valid(s_word_valid), .word_data(s_word_data),
    .word_ready(s_word_ready), .abort(s_abort), .clear_count(s_clear),
    .pd_data(s_pd_data), .pd_trig(s_pd_trig), .pd_led(s_pd_led), .pd_on_led(s_on_led),
    .led_snap(s_led_snap), .match_count(s_match), .busy(s_busy), .done(s_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cnt;
    int led;
  } done_exp_t;

  bit        exp_bits[$];
  done_exp_t exp_done[$];
  int        sat_exp[$];
  done_exp_t e;

  logic [WW-1:0] on_mask  = '0;
  logic [LW-1:0] last_led = '0;
  int  k             = 0;
  int  acc_cyc       = 0;
  int  last_done_cyc = -100;
  int  last_trig_cyc = 0;
  int  trig_in_word  = 0;
  int  total_trigs   = 0;
  bit  expect_b2b    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor plus mock detector, both away from the active edge.
  always @(negedge clk) begin
    if (pd_trig) begin
      if (exp_bits.size() == 0) check("unexpected_trig", 1, 0);
      else check("trig_data", int'(pd_data), int'(exp_bits.pop_front()));
      if (trig_in_word > 0) check("trig_spacing", cyc - last_trig_cyc, PERIOD);
      last_trig_cyc = cyc;
      trig_in_word++;
      total_trigs++;
    end
    if (done) begin
      if (exp_done.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = exp_done.pop_front();
        check("done_count", int'(match_count), e.cnt);
        check("done_led", int'(led_snap), e.led);
      end
      check("accept_to_done", cyc - acc_cyc, LAT);
      last_done_cyc = cyc;
    end
    if (word_valid && word_ready) begin
      if (expect_b2b) check("b2b_accept_gap", cyc - last_done_cyc, 1);
      acc_cyc      = cyc;
      trig_in_word = 0;
      k            = 0;
      pd_on_led    = 1'b0;
      pd_led       = '0;
    end else if (pd_trig && k < WW) begin
      pd_on_led = on_mask[k];
      pd_led    = (k == WW - 1) ? last_led : '0;
      k++;
    end
    if (s_done) begin
      if (sat_exp.size() == 0) check("sat_unexpected_done", 1, 0);
      else check("sat_done_count", int'(s_match), sat_exp.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WW-1:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(d[WW-1-i]);
  endtask

  task automatic send(input logic [WW-1:0] d);
    int t;
    t = 0;
    word_data  = d;
    word_valid = 1'b1;
    while (!word_ready && t < 200) begin tick(); t++; end
    if (t >= 200) check("accept_timeout", 1, 0);
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 200) begin tick(); t++; end
    if (t >= 200) check("done_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_trigs(input int n, input bit sat);
    int c, t;
    c = 0;
    t = 0;
    while (t < 300) begin
      if (sat ? s_pd_trig : pd_trig) c++;
      if (c >= n) break;
      tick();
      t++;
    end
    if (c < n) check("trig_timeout", c, n);
  endtask

  task automatic s_send(input logic [WW-1:0] d);
    int t;
    t = 0;
    s_word_data  = d;
    s_word_valid = 1'b1;
    while (!s_word_ready && t < 200) begin tick(); t++; end
    if (t >= 200) check("sat_accept_timeout", 1, 0);
    tick();
    s_word_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, t;
    reset = 1'b1; word_valid = 1'b0; word_data = '0; abort = 1'b0; clear_count = 1'b0;
    pd_on_led = 1'b0; pd_led = '0;
    s_word_valid = 1'b0; s_word_data = '0; s_abort = 1'b0; s_clear = 1'b0;
    s_on_led = 1'b1; s_pd_led = '0;

    repeat (3) begin
      tick();
      check("ready_in_reset", int'(word_ready), 0);
    end
    check("reset_busy", int'(busy), 0);
    check("reset_trig", int'(pd_trig), 0);
    check("reset_count", int'(match_count), 0);
    check("reset_led_snap", int'(led_snap), 0);
    reset = 1'b0;
    tick();
    check("ready_idle", int'(word_ready), 1);
    check("idle_pd_data", int'(pd_data), 0);

    // 1: 8'h2E -> 0,0,1,0,1,1,1,0
    on_mask = '0; last_led = '0;
    push_word(8'h2E, 8);
    exp_done.push_back('{0, 0});
    send(8'h2E);
    wait_done();
    check("t1_ready_after", int'(word_ready), 1);

    // 2: matches on bits 2 and 4, led 10101 at the last sample
    on_mask = 8'b0000_1010; last_led = 5'b10101;
    push_word(8'hA5, 8);
    exp_done.push_back('{2, 21});
    send(8'hA5);
    wait_done();
    check("t2_count", int'(match_count), 2);
    check("t2_led", int'(led_snap), 21);

    // 3: back-to-back FF then 00 with valid held high
    on_mask = '0; last_led = '0;
    push_word(8'hFF, 8);
    push_word(8'h00, 8);
    exp_done.push_back('{2, 0});
    exp_done.push_back('{2, 0});
    base = total_trigs;
    word_data = 8'hFF; word_valid = 1'b1;
    t = 0;
    while (!word_ready && t < 200) begin tick(); t++; end
    tick();
    word_data  = 8'h00;
    expect_b2b = 1'b1;
    wait_done();
    tick();
    word_valid = 1'b0;
    expect_b2b = 1'b0;
    wait_done();
    check("t3_trig_total", total_trigs - base, 16);

    // 4: abort in the first HOLD cycle of bit 3
    on_mask = 8'b0000_0001; last_led = '0;
    push_word(8'hF0, 3);
    send(8'hF0);
    wait_trigs(3, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_ready", int'(word_ready), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_count", int'(match_count), 3);
    repeat (30) tick();
    check("t4_count_hold", int'(match_count), 3);
    check("t4_led_hold", int'(led_snap), 0);

    // 6: reset during TRIG of bit 2, then 8'h81
    on_mask = '0; last_led = '0;
    push_word(8'h3C, 2);
    send(8'h3C);
    wait_trigs(2, 1'b0);
    reset = 1'b1;
    tick();
    check("t6_pd_data", int'(pd_data), 0);
    check("t6_pd_trig", int'(pd_trig), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_count", int'(match_count), 0);
    check("t6_led_snap", int'(led_snap), 0);
    check("t6_ready_in_reset", int'(word_ready), 0);
    reset = 1'b0;
    tick();
    check("t6_ready", int'(word_ready), 1);
    push_word(8'h81, 8);
    exp_done.push_back('{0, 0});
    send(8'h81);
    wait_done();

    // 5: 3-bit counter saturates, then clear on the final SAMPLE wins
    sat_exp.push_back(7);
    s_send(8'h55);
    t = 0;
    while (!s_done && t < 200) begin tick(); t++; end
    if (t >= 200) check("sat_done_timeout", 1, 0);
    tick();
    check("sat_count_7", int'(s_match), 7);
    sat_exp.push_back(0);
    s_send(8'hAA);
    wait_trigs(8, 1'b1);
    repeat (3) tick();
    check("sat_hold_7", int'(s_match), 7);
    s_clear = 1'b1;
    tick();
    s_clear = 1'b0;
    check("sat_clear_wins", int'(s_match), 0);
    repeat (5) tick();

    repeat (10) tick();
    check("bits_left", exp_bits.size(), 0);
    check("dones_left", exp_done.size(), 0);
    check("sat_dones_left", sat_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_stream_sequencer.md
Name: pd_stream_sequencer

Overview:
Sequencer that drives the serial pattern-detector FSM (data/trig/led/on_led interface). It accepts parallel words over a valid/ready handshake and serializes each word MSB-first onto pd_data. Each bit gets a one-cycle pd_trig strobe with setup and hold margins. After each bit it samples the detector's led/on_led response, keeps a saturating match counter, and reports per-word completion.

Parameters:
- WORD_W, 8: bits per accepted word; must be ≥1.
- GAP_CYCLES, 2: hold cycles after each trig before sampling the detector; must be ≥1.
- CNT_W, 16: width of match_count.
- LED_W, 5: width of the detector led bus.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high.
- word_valid, input, 1: upstream word available.
- word_data, input, WORD_W: word to serialize, MSB first.
- word_ready, output, 1: sequencer can accept a word.
- abort, input, 1: cancel the word in progress.
- clear_count, input, 1: zero match_count.
- pd_data, output, 1: serial bit to detector.
- pd_trig, output, 1: one-cycle strobe qualifying pd_data.
- pd_led, input, LED_W: detector led bus.
- pd_on_led, input, 1: detector match indicator.
- led_snap, output, LED_W: pd_led captured at the last sample point.
- match_count, output, CNT_W: saturating count of sample points with pd_on_led=1.
- busy, output, 1: word in progress.
- done, output, 1: one-cycle pulse when a word completes.

Behaviour:
- Reset (sync; takes effect at the posedge where reset=1):
  - state=IDLE.
  - pd_data, pd_trig, led_snap, match_count, busy, done = 0.
  - Shift register and counters = 0.
  - word_ready=0 while reset=1.
- States: IDLE, SETUP, TRIG, HOLD, SAMPLE, DONE.
- IDLE:
  - word_ready=1 (when reset=0), busy=0, pd_data=0.
  - On word_valid && word_ready: load shreg=word_data, bit_cnt=WORD_W-1, go to SETUP.
- SETUP (1 cycle):
  - pd_data=shreg[WORD_W-1], pd_trig=0 → TRIG.
- TRIG (1 cycle):
  - pd_trig=1, pd_data unchanged.
  - Load gap_cnt=GAP_CYCLES-1 → HOLD.
- HOLD:
  - pd_trig=0, pd_data held.
  - gap_cnt decrements each cycle; at gap_cnt==0 → SAMPLE.
  - HOLD lasts exactly GAP_CYCLES cycles.
- SAMPLE (1 cycle):
  - led_snap<=pd_led.
  - If pd_on_led, match_count<=match_count+1, saturating at all-ones.
  - If bit_cnt==0 → DONE; else shreg<<=1, bit_cnt--, → SETUP.
- DONE (1 cycle):
  - done=1, word_ready=0 → IDLE.
- Timing:
  - Per-bit period = GAP_CYCLES+3 cycles.
  - pd_data is stable for 1 cycle before pd_trig and for GAP_CYCLES+1 cycles after it.
  - Accept-to-done latency = WORD_W·(GAP_CYCLES+3)+1 cycles.
  - Back-to-back words: next accept occurs no earlier than 1 cycle after done.
- Handshake:
  - word_data is sampled only on the accept cycle.
  - word_valid is ignored outside IDLE.
- busy = 1 in SETUP, TRIG, HOLD, SAMPLE and DONE.
- abort:
  - In any non-IDLE state, next state is IDLE and pd_trig is forced 0 in that cycle.
  - No done pulse; the partial word is discarded.
  - match_count and led_snap keep their values.
  - abort in IDLE has no effect.
  - abort together with an accept in IDLE: the accept proceeds.
- clear_count:
  - match_count<=0.
  - Coincident with a SAMPLE increment, clear wins (result 0).
- Priority: reset > abort > normal sequencing.

Decomposition:
- Package pd_seq_pkg: state enum (IDLE, SETUP, TRIG, HOLD, SAMPLE, DONE) and default parameter constants.
- One sub-module pd_bit_serializer:
  - Parallel-load shift register plus bit counter.
  - Ports: load, shift, load_data, bit_out, last.
- FSM, gap timer and counter stay in the top.

Test Plan:
1. WORD_W=8, GAP=2, word 8'h2E after reset.
   → pd_data at the 8 trig strobes is 0,0,1,0,1,1,1,0.
   → trig strobes are 5 cycles apart; done 41 cycles after accept.
   → word_ready=0 during reset, 1 in IDLE.
2. Mock detector drives pd_on_led=1 at the SAMPLE of bits 2 and 4, and pd_led=5'b10101 at the last sample.
   → match_count=2, led_snap=5'b10101 after done.
3. word_valid held high with 8'hFF then 8'h00.
   → second accept occurs exactly 1 cycle after the first done; exactly 16 trig pulses total; the second word drives all zeros.
4. abort asserted in HOLD of bit 3.
   → next cycle IDLE, word_ready=1, no done, no further pd_trig; match_count unchanged.
5. CNT_W=3, pd_on_led tied 1, two words.
   → match_count saturates at 7.
   → clear_count coincident with a SAMPLE leaves 0.
6. reset asserted mid-word in TRIG.
   → next cycle all outputs 0, state IDLE.
   → after release, a new word 8'h81 serializes correctly.
